// File: rtl/bip_sequencer.sv
// Fetch/decode sequencer for the accumulator datapath; every output is a flop.
// Optional BIP_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter output.
module bip_sequencer #(
  parameter int bits_address = 11,
  parameter int bits_opcode  = 5
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [bits_opcode+bits_address-1:0] instr,
  output logic [bits_address-1:0]             prog_addr,
  output logic                                prog_rd,
  output logic [bits_address-1:0]             data_addr,
  output logic [bits_address-1:0]             operand,
  output logic                                rd_ram,
  output logic                                wr_ram,
  output logic                                wr_acc,
  output logic [1:0]                          sel_a,
  output logic                                sel_b,
  output logic                                alu_op,
  output logic                                busy,
  output logic                                halted,
  output logic                                illegal
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]                         cycle_count
`endif
);

  localparam int IW = bits_opcode + bits_address;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [bits_opcode-1:0] OP_HLT  = bits_opcode'(0);
  localparam logic [bits_opcode-1:0] OP_STO  = bits_opcode'(1);
  localparam logic [bits_opcode-1:0] OP_LD   = bits_opcode'(2);
  localparam logic [bits_opcode-1:0] OP_LDI  = bits_opcode'(3);
  localparam logic [bits_opcode-1:0] OP_ADD  = bits_opcode'(4);
  localparam logic [bits_opcode-1:0] OP_ADDI = bits_opcode'(5);
  localparam logic [bits_opcode-1:0] OP_SUB  = bits_opcode'(6);
  localparam logic [bits_opcode-1:0] OP_SUBI = bits_opcode'(7);

  logic [2:0]              state, state_n;
  logic [bits_address-1:0] pc, pc_n;
  logic [IW-1:0]           ir, ir_n;
  logic [bits_opcode-1:0]  op_n;
  logic                    ill_n;
  logic                    prog_rd_n, rd_ram_n, wr_ram_n, wr_acc_n;
  logic [1:0]              sel_a_n;
  logic                    sel_b_n, alu_op_n, busy_n, halted_n;

  assign prog_addr = pc;
  assign operand   = ir[bits_address-1:0];
  assign data_addr = ir[bits_address-1:0];

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    ill_n   = illegal;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
          ill_n   = 1'b0;
        end
      end
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        ir_n = instr;
        case (instr[IW-1 -: bits_opcode])
          OP_HLT:                         state_n = S_HALT;
          OP_LD, OP_ADD, OP_SUB:          state_n = S_MEMRD;
          OP_STO, OP_LDI, OP_ADDI, OP_SUBI: state_n = S_EXEC;
          default: begin
            state_n = S_EXEC;
            ill_n   = 1'b1;
          end
        endcase
      end
      S_MEMRD: state_n = S_EXEC;
      S_EXEC: begin
        pc_n    = pc + bits_address'(1);
        state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    op_n      = ir_n[IW-1 -: bits_opcode];
    prog_rd_n = (state_n == S_FETCH);
    rd_ram_n  = (state_n == S_MEMRD);
    busy_n    = (state_n != S_IDLE) && (state_n != S_HALT);
    halted_n  = (state_n == S_HALT);
    wr_ram_n  = 1'b0;
    wr_acc_n  = 1'b0;
    sel_a_n   = 2'b00;
    sel_b_n   = 1'b0;
    alu_op_n  = 1'b0;
    if (state_n == S_EXEC) begin
      case (op_n)
        OP_STO:  wr_ram_n = 1'b1;
        OP_LD:   wr_acc_n = 1'b1;
        OP_LDI: begin
          wr_acc_n = 1'b1;
          sel_a_n  = 2'b01;
        end
        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
          wr_acc_n = 1'b1;
          sel_a_n  = 2'b10;
          sel_b_n  = (op_n == OP_ADDI) || (op_n == OP_SUBI);
          alu_op_n = (op_n == OP_SUB) || (op_n == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
      prog_rd <= 1'b0;
      rd_ram  <= 1'b0;
      wr_ram  <= 1'b0;
      wr_acc  <= 1'b0;
      sel_a   <= 2'b00;
      sel_b   <= 1'b0;
      alu_op  <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      illegal <= ill_n;
      prog_rd <= prog_rd_n;
      rd_ram  <= rd_ram_n;
      wr_ram  <= wr_ram_n;
      wr_acc  <= wr_acc_n;
      sel_a   <= sel_a_n;
      sel_b   <= sel_b_n;
      alu_op  <= alu_op_n;
      busy    <= busy_n;
      halted  <= halted_n;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      cycle_count <= '0;
    else if (start && ((state == S_IDLE) || (state == S_HALT)))
      cycle_count <= '0;
    else if (busy)
      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bip_sequencer.sv
// Scoreboarded bench for bip_sequencer: expected strobe events are queued per
// program and matched against every strobe the DUT raises.
module tb_bip_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start;
  logic [15:0] instr = '0;
  logic [10:0] prog_addr, data_addr, operand;
  logic        prog_rd, rd_ram, wr_ram, wr_acc, sel_b, alu_op, busy, halted, illegal;
  logic [1:0]  sel_a;
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cycle_count, s_cycle_count;
`endif

  logic       s_reset_n, s_start;
  logic [7:0] s_instr = '0;
  logic [2:0] s_prog_addr, s_data_addr, s_operand;
  logic       s_prog_rd, s_rd_ram, s_wr_ram, s_wr_acc, s_sel_b, s_alu_op;
  logic       s_busy, s_halted, s_illegal;
  logic [1:0] s_sel_a;

  bip_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
    .prog_addr(prog_addr), .prog_rd(prog_rd), .data_addr(data_addr), .operand(operand),
    .rd_ram(rd_ram), .wr_ram(wr_ram), .wr_acc(wr_acc), .sel_a(sel_a), .sel_b(sel_b),
    .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal)
`ifdef BIP_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  bip_sequencer #(.bits_address(3), .bits_opcode(5)) u_small (
    .clk(clk), .reset_n(s_reset_n), .start(s_start), .instr(s_instr),
    .prog_addr(s_prog_addr), .prog_rd(s_prog_rd), .data_addr(s_data_addr), .operand(s_operand),
    .rd_ram(s_rd_ram), .wr_ram(s_wr_ram), .wr_acc(s_wr_acc), .sel_a(s_sel_a), .sel_b(s_sel_b),
    .alu_op(s_alu_op), .busy(s_busy), .halted(s_halted), .illegal(s_illegal)
`ifdef BIP_CYCLE_COUNT_EN
    , .cycle_count(s_cycle_count)
`endif
  );

  logic [15:0] prog [0:2047];
  logic [7:0]  s_prog [0:7];
  always @(posedge clk) if (prog_rd) instr <= prog[prog_addr];
  always @(posedge clk) if (s_prog_rd) s_instr <= s_prog[s_prog_addr];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         rel;
    logic [2:0] strb;   // {rd_ram, wr_ram, wr_acc}
    logic [1:0] sa;
    logic       sb;
    logic       ao;
    logic [10:0] addr;
  } ev_t;
  ev_t exp_q[$];

  function automatic ev_t mk(int rel, logic [2:0] strb, logic [1:0] sa, logic sb, logic ao,
                             logic [10:0] addr);
    ev_t e;
    e.rel = rel; e.strb = strb; e.sa = sa; e.sb = sb; e.ao = ao; e.addr = addr;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rd_ram || wr_ram || wr_acc) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe rel=%0d strb=%b got none expected", cyc - start_cyc + 1,
                 {rd_ram, wr_ram, wr_acc});
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ((cyc - start_cyc + 1) !== e.rel || {rd_ram, wr_ram, wr_acc} !== e.strb ||
            sel_a !== e.sa || sel_b !== e.sb || alu_op !== e.ao || data_addr !== e.addr) begin
          mismatched++;
          $display("FAIL strobe_event got rel=%0d strb=%b sa=%b sb=%b ao=%b addr=%h expected rel=%0d strb=%b sa=%b sb=%b ao=%b addr=%h",
                   cyc - start_cyc + 1, {rd_ram, wr_ram, wr_acc}, sel_a, sel_b, alu_op, data_addr,
                   e.rel, e.strb, e.sa, e.sb, e.ao, e.addr);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_reset_n = 1'b0; start = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, halted, illegal, prog_rd, rd_ram, wr_ram, wr_acc} !== 7'b0 || prog_addr !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_state got flags=%b pc=%h expected flags=0 pc=0",
               {busy, halted, illegal, prog_rd, rd_ram, wr_ram, wr_acc}, prog_addr);
    end
`ifdef BIP_CYCLE_COUNT_EN
    compared++;
    if (cycle_count !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_cycle_count got %0d expected 0", cycle_count);
    end
`endif
    reset_n = 1'b1; s_reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program();
    prog[0] = {5'd3, 11'd5}; prog[1] = {5'd5, 11'd3}; prog[2] = {5'd1, 11'd7}; prog[3] = 16'h0;
    exp_q.push_back(mk(3, 3'b001, 2'b01, 1'b0, 1'b0, 11'd5));
    exp_q.push_back(mk(6, 3'b001, 2'b10, 1'b1, 1'b0, 11'd3));
    exp_q.push_back(mk(9, 3'b010, 2'b00, 1'b0, 1'b0, 11'd7));
    pulse_start();
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    compared++;
    if (!halted || (cyc - start_cyc + 1) !== 12 || prog_addr !== 11'd3 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL program_halt got halted=%b rel=%0d pc=%h busy=%b expected halted=1 rel=12 pc=3 busy=0",
               halted, cyc - start_cyc + 1, prog_addr, busy);
    end
`ifdef BIP_CYCLE_COUNT_EN
    compared++;
    if (cycle_count !== 32'd11) begin
      mismatched++;
      $display("FAIL program_cycle_count got %0d expected 11", cycle_count);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (cycle_count !== 32'd11) begin
      mismatched++;
      $display("FAIL halt_count_frozen got %0d expected 11", cycle_count);
    end
`endif
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL program_events_left got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_load_mem();
    prog[0] = {5'd2, 11'h010}; prog[1] = 16'h0;
    exp_q.push_back(mk(3, 3'b100, 2'b00, 1'b0, 1'b0, 11'h010));
    exp_q.push_back(mk(4, 3'b001, 2'b00, 1'b0, 1'b0, 11'h010));
    pulse_start();
    for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
    compared++;
    if (!halted || (cyc - start_cyc + 1) !== 7 || prog_addr !== 11'd1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL load_mem_halt got halted=%b rel=%0d pc=%h left=%0d expected halted=1 rel=7 pc=1 left=0",
               halted, cyc - start_cyc + 1, prog_addr, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_exec();
    prog[0] = {5'd4, 11'h020}; prog[1] = 16'h0;
    exp_q.push_back(mk(3, 3'b100, 2'b00, 1'b0, 1'b0, 11'h020));
    exp_q.push_back(mk(4, 3'b001, 2'b10, 1'b0, 1'b0, 11'h020));
    pulse_start();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({busy, halted, wr_acc, prog_rd, rd_ram, wr_ram} !== 6'b0 || prog_addr !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_mid_exec got flags=%b pc=%h expected flags=0 pc=0",
               {busy, halted, wr_acc, prog_rd, rd_ram, wr_ram}, prog_addr);
    end
`ifdef BIP_CYCLE_COUNT_EN
    compared++;
    if (cycle_count !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid_exec_count got %0d expected 0", cycle_count);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL reset_stays_idle got busy=%b left=%0d expected busy=0 left=0", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_illegal();
    prog[0] = {5'h1F, 11'd5}; prog[1] = 16'h0;
    pulse_start();
    repeat (2) @(negedge clk);
    compared++;
    if (illegal !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_in_exec got illegal=%b busy=%b expected 1 1", illegal, busy);
    end
    @(negedge clk);
    compared++;
    if (prog_addr !== 11'd1 || prog_rd !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_pc_inc got pc=%h prog_rd=%b expected pc=1 prog_rd=1", prog_addr, prog_rd);
    end
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    compared++;
    if (!halted || illegal !== 1'b1 || prog_addr !== 11'd1) begin
      mismatched++;
      $display("FAIL illegal_sticky got halted=%b illegal=%b pc=%h expected 1 1 1", halted, illegal, prog_addr);
    end
  endtask

  task automatic test_back_to_back();
    prog[0] = {5'd3, 11'd1}; prog[1] = {5'd3, 11'd2}; prog[2] = 16'h0;
    exp_q.push_back(mk(3, 3'b001, 2'b01, 1'b0, 1'b0, 11'd1));
    exp_q.push_back(mk(6, 3'b001, 2'b01, 1'b0, 1'b0, 11'd2));
    pulse_start();
    compared++;
    if (prog_addr !== 11'd0 || illegal !== 1'b0 || busy !== 1'b1 || halted !== 1'b0 || prog_rd !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_from_halt got pc=%h illegal=%b busy=%b halted=%b prog_rd=%b expected 0 0 1 0 1",
               prog_addr, illegal, busy, halted, prog_rd);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
    compared++;
    if (!halted || (cyc - start_cyc + 1) !== 9 || prog_addr !== 11'd2 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL start_while_busy got halted=%b rel=%0d pc=%h left=%0d expected 1 rel=9 pc=2 left=0",
               halted, cyc - start_cyc + 1, prog_addr, exp_q.size());
      exp_q.delete();
    end
`ifdef BIP_CYCLE_COUNT_EN
    compared++;
    if (cycle_count !== 32'd8) begin
      mismatched++;
      $display("FAIL busy_start_count got %0d expected 8", cycle_count);
    end
`endif
  endtask

  task automatic test_pc_wrap();
    logic [2:0] exp_pc;
    int fetches;
    exp_pc = 3'd0;
    fetches = 0;
    for (int i = 0; i < 8; i++) s_prog[i] = 8'h18;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 60 && fetches < 10; i++) begin
      if (s_prog_rd) begin
        compared++;
        if (s_prog_addr !== exp_pc) begin
          mismatched++;
          $display("FAIL pc_wrap_fetch got pc=%0d expected %0d", s_prog_addr, exp_pc);
        end
        exp_pc = exp_pc + 3'd1;
        fetches++;
      end
      @(negedge clk);
    end
    compared++;
    if (fetches != 10 || s_halted !== 1'b0 || s_illegal !== 1'b0) begin
      mismatched++;
      $display("FAIL pc_wrap_run got fetches=%0d halted=%b illegal=%b expected 10 0 0",
               fetches, s_halted, s_illegal);
    end
    s_reset_n = 1'b0;
    @(negedge clk);
    s_reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0;
    test_reset();
    test_program();
    test_load_mem();
    test_reset_mid_exec();
    test_illegal();
    test_back_to_back();
    test_pc_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
